// File: rtl/vga_tile_pkg.sv
// Shared encoding layout, shape codes and colour constants for the tile renderer.
package vga_tile_pkg;

  localparam int unsigned SHAPE_W   = 3;
  localparam int unsigned COLOR_W   = 2;
  localparam int unsigned TILE_W    = 6;
  localparam int unsigned SHAPE_LSB = 0;
  localparam int unsigned COLOR_LSB = 3;
  localparam int unsigned BLINK_BIT = 5;

  localparam logic [SHAPE_W-1:0] SHAPE_NONE   = 3'd0;
  localparam logic [SHAPE_W-1:0] SHAPE_UP     = 3'd1;
  localparam logic [SHAPE_W-1:0] SHAPE_DOWN   = 3'd2;
  localparam logic [SHAPE_W-1:0] SHAPE_LEFT   = 3'd3;
  localparam logic [SHAPE_W-1:0] SHAPE_RIGHT  = 3'd4;
  localparam logic [SHAPE_W-1:0] SHAPE_SQUARE = 3'd5;

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_BG     = 12'hEEE;
  localparam logic [11:0] RGB_CURSOR = 12'h0F0;

  function automatic logic [11:0] palette(input logic [COLOR_W-1:0] color);
    logic [11:0] rgb;
    unique case (color)
      2'd0:    rgb = 12'hC00;
      2'd1:    rgb = 12'hFE0;
      2'd2:    rgb = 12'h166;
      default: rgb = 12'h35C;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_tile_renderer_if.sv
// Pixel stream into the renderer and coloured pixel stream out to the DAC.
interface vga_tile_renderer_if;
  logic        de_in;
  logic [9:0]  x_in;
  logic [9:0]  y_in;
  logic [11:0] rgb_out;
  logic        de_out;

  modport master (output de_in, x_in, y_in, input rgb_out, de_out);
  modport slave (input de_in, x_in, y_in, output rgb_out, de_out);
endinterface

// File: rtl/vga_glyph_hit.sv
// Combinational glyph hit test for one tile-relative pixel; all glyphs derive from the up arrow.
module vga_glyph_hit
  import vga_tile_pkg::*;
#(
  parameter int unsigned TILE_SIZE = 200
) (
  input  logic [SHAPE_W-1:0] shape,
  input  logic [9:0]         x_rel,
  input  logic [9:0]         y_rel,
  output logic               hit
);

  localparam int unsigned U = TILE_SIZE / 10;
  localparam int unsigned H = U / 2;

  function automatic logic in_rng(input logic [9:0] v, input int unsigned lo, input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

  function automatic logic up_hit(input logic [9:0] x, input logic [9:0] y);
    return (in_rng(y, U, 2 * U)     && in_rng(x, 9 * H, 11 * H)) ||
           (in_rng(y, 2 * U, 3 * U) && in_rng(x, 4 * U, 6 * U))  ||
           (in_rng(y, 3 * U, 4 * U) && in_rng(x, 7 * H, 13 * H)) ||
           (in_rng(y, 4 * U, 5 * U) && in_rng(x, 3 * U, 7 * U))  ||
           (in_rng(y, 5 * U, 9 * U) && in_rng(x, 9 * H, 11 * H));
  endfunction

  logic [9:0] x_flip, y_flip;
  assign x_flip = 10'(TILE_SIZE - 1) - x_rel;
  assign y_flip = 10'(TILE_SIZE - 1) - y_rel;

  always_comb begin
    hit = 1'b0;
    case (shape)
      SHAPE_UP:     hit = up_hit(x_rel, y_rel);
      SHAPE_DOWN:   hit = up_hit(x_rel, y_flip);
      SHAPE_LEFT:   hit = up_hit(y_rel, x_rel);
      SHAPE_RIGHT:  hit = up_hit(y_rel, x_flip);
      SHAPE_SQUARE: hit = in_rng(x_rel, 4 * U, 6 * U) && in_rng(y_rel, 4 * U, 6 * U);
      default:      hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/vga_tile_renderer.sv
// Two-stage tile grid renderer with frame-synchronous shadow encoding, blinking and cursor outline.
module vga_tile_renderer
  import vga_tile_pkg::*;
#(
  parameter int unsigned N_COLS       = 3,
  parameter int unsigned N_ROWS       = 2,
  parameter int unsigned TILE_SIZE    = 200,
  parameter int unsigned X0           = 20,
  parameter int unsigned Y0           = 40,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned CURSOR_W     = 4,
  localparam int unsigned N_TILES     = N_COLS * N_ROWS,
  localparam int unsigned TIDX_W      = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [TILE_W*N_TILES-1:0] encode_in,
  input  logic                      cursor_en,
  input  logic [TIDX_W-1:0]         cursor_tile,
  vga_tile_renderer_if.slave        pix
);

  localparam int unsigned BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [TILE_W*N_TILES-1:0] shadow_q;
  logic [BCW-1:0]            blink_cnt_q;
  logic                      phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (frame_start) begin
      shadow_q <= encode_in;
      if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BCW'(1);
      end
    end
  end

  // Stage 1: locate the tile with a compare chain and look up its encoding from the old shadow.
  logic [10:0]       xa, ya, x_base, y_base;
  int unsigned       col, row;
  logic              in_grid_d, curs_d;
  logic [TIDX_W-1:0] tile_d;
  logic [TILE_W-1:0] enc_d;

  assign xa = {1'b0, pix.x_in};
  assign ya = {1'b0, pix.y_in};

  always_comb begin
    col    = 0;
    row    = 0;
    x_base = 11'(X0);
    y_base = 11'(Y0);
    for (int unsigned k = 1; k < N_COLS; k++) begin
      if (xa >= 11'(X0 + k * TILE_SIZE)) begin
        col    = k;
        x_base = 11'(X0 + k * TILE_SIZE);
      end
    end
    for (int unsigned k = 1; k < N_ROWS; k++) begin
      if (ya >= 11'(Y0 + k * TILE_SIZE)) begin
        row    = k;
        y_base = 11'(Y0 + k * TILE_SIZE);
      end
    end
    in_grid_d = (xa >= 11'(X0)) && (xa < 11'(X0 + N_COLS * TILE_SIZE)) &&
                (ya >= 11'(Y0)) && (ya < 11'(Y0 + N_ROWS * TILE_SIZE));
    tile_d = TIDX_W'(row * N_COLS + col);
    enc_d  = '0;
    for (int unsigned i = 0; i < N_TILES; i++) begin
      if (tile_d == TIDX_W'(i)) enc_d = shadow_q[i*TILE_W +: TILE_W];
    end
    // tile_d never exceeds N_TILES-1, so out-of-range cursor indices cannot match
    curs_d = cursor_en && (cursor_tile == tile_d);
  end

  logic              de1_q, in_grid1_q, curs1_q, phase1_q;
  logic [9:0]        xrel1_q, yrel1_q;
  logic [TILE_W-1:0] enc1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      de1_q      <= 1'b0;
      in_grid1_q <= 1'b0;
      curs1_q    <= 1'b0;
      phase1_q   <= 1'b0;
      xrel1_q    <= '0;
      yrel1_q    <= '0;
      enc1_q     <= '0;
    end else begin
      de1_q      <= pix.de_in;
      in_grid1_q <= in_grid_d;
      curs1_q    <= curs_d;
      phase1_q   <= phase_q;
      xrel1_q    <= 10'(xa - x_base);
      yrel1_q    <= 10'(ya - y_base);
      enc1_q     <= enc_d;
    end
  end

  // Stage 2: glyph test and colour priority.
  logic        glyph_hit, border;
  logic [11:0] rgb_d, rgb_q;
  logic        de2_q;

  vga_glyph_hit #(
    .TILE_SIZE(TILE_SIZE)
  ) u_glyph (
    .shape(enc1_q[SHAPE_LSB +: SHAPE_W]),
    .x_rel(xrel1_q),
    .y_rel(yrel1_q),
    .hit  (glyph_hit)
  );

  assign border = (xrel1_q < 10'(CURSOR_W)) || (xrel1_q >= 10'(TILE_SIZE - CURSOR_W)) ||
                  (yrel1_q < 10'(CURSOR_W)) || (yrel1_q >= 10'(TILE_SIZE - CURSOR_W));

  always_comb begin
    rgb_d = RGB_BG;
    if (!de1_q || !in_grid1_q) begin
      rgb_d = RGB_BLACK;
    end else if (curs1_q && border) begin
      rgb_d = RGB_CURSOR;
    end else if (enc1_q[BLINK_BIT] && !phase1_q) begin
      rgb_d = RGB_BG;
    end else if (glyph_hit) begin
      rgb_d = palette(enc1_q[COLOR_LSB +: COLOR_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= RGB_BLACK;
      de2_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      de2_q <= de1_q;
    end
  end

  assign pix.rgb_out = rgb_q;
  assign pix.de_out  = de2_q;

endmodule
